uart_tx_fifo: RTL

//   Parametrised UART transmitter with an input FIFO, for the iCE40 tester top level.

---
 rtl/uart_tx_fifo.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO. Words arrive on a valid/ready handshake,
// are buffered, and are serialised on ftdi_tx. Bit timing comes from a clock-enable
// divider on hwclk; no derived clock is used.
module uart_tx_fifo #(
  parameter int unsigned CLK_HZ     = 12000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          hwclk,
  input  logic                          rst_n,
  input  logic [DATA_BITS-1:0]          in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          ftdi_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned DIV   = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int unsigned DIV_W = $clog2(DIV);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned LW    = AW + 1;

  // Reject illegal parameter sets at elaboration
  if (DIV < 2) begin : g_err_div
    $error("uart_tx_fifo: DIV must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_err_data
    $error("uart_tx_fifo: DATA_BITS must be 5..8");
  end
  if (PARITY > 2) begin : g_err_parity
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_err_stop
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_err_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  state_e               state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]        level_q, level_d;
  logic                 ready_q, ready_d;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];

  logic                 push_c, pop_c, load_c, tick_c;
  logic [DATA_BITS-1:0] head_c;

  assign push_c     = in_valid && ready_q;
  assign tick_c     = (div_q == DIV_W'(DIV - 1));
  assign head_c     = mem[rd_ptr_q];
  assign in_ready   = ready_q;
  assign ftdi_tx    = tx_q;
  assign busy       = busy_q;
  assign fifo_level = level_q;

  // Next-state and line-value logic for the frame sequencer
  always_comb begin
    state_d = state_q;
    div_d   = tick_c ? '0 : div_q + DIV_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    load_c  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        div_d = '0;
        tx_d  = 1'b1;
        if (level_q != '0) load_c = 1'b1;
      end
      S_START: begin
        if (tick_c) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (tick_c) begin
          if (bit_q == 3'(DATA_BITS - 1)) begin
            bit_d = '0;
            if (PARITY != 0) begin
              state_d = S_PARITY;
              tx_d    = (PARITY == 2) ? ~par_q : par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (tick_c) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
          bit_d   = '0;
        end
      end
      S_STOP: begin
        if (tick_c) begin
          if (bit_q == 3'(STOP_BITS - 1)) begin
            if (level_q != '0) begin
              load_c = 1'b1;
            end else begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
            end
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Pop the head word and open a new frame with its start bit
    if (load_c) begin
      state_d = S_START;
      shift_d = head_c;
      par_d   = ^head_c;
      tx_d    = 1'b0;
      busy_d  = 1'b1;
      div_d   = '0;
      bit_d   = '0;
    end
  end

  assign pop_c = load_c;

  // FIFO occupancy; in_ready is registered from the next level so it never depends on in_valid
  always_comb begin
    level_d = level_q + LW'(push_c) - LW'(pop_c);
    ready_d = (level_d != LW'(FIFO_DEPTH));
  end

  // Sequencer, divider, pointers and registered outputs
  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      level_q <= level_d;
      ready_q <= ready_d;
      if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge hwclk) begin
    if (push_c) mem[wr_ptr_q] <= in_data;
  end

endmodule
